self_clean_ctrl: RTL and testbench

//  Range-hood self-clean sequencer: start request launches a fixed-length clean cycle,

---
 rtl/hood_pkg.sv | 23 ++
 rtl/clean_tick_gen.sv | 38 +++
 rtl/self_clean_ctrl.sv | 171 +++++++++++++++++
 tb/tb_self_clean_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hood_pkg.sv
// Shared types and constants for the range-hood self-clean sequencer.
// Holds the FSM state encoding, the BCD digit type and the seconds-to-MM:SS conversion.
package hood_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLEANING = 2'd1,
    ST_PAUSED   = 2'd2,
    ST_FINISHED = 2'd3
  } clean_state_e;

  typedef logic [3:0] bcd_digit_t;

  // Elaboration-time conversion used only for the reset/reload display value.
  function automatic logic [15:0] sec_to_bcd(input int secs);
    int mins;
    int s;
    mins = secs / 60;
    s    = secs % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

endpackage

// File: rtl/clean_tick_gen.sv
// 1 Hz tick prescaler for the self-clean countdown: counts 0..CLK_HZ-1 and flags
// the terminal count; clr forces zero, hold freezes the count in place.
module clean_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] TC = PRE_W'(CLK_HZ - 1);

  logic [PRE_W-1:0] cnt_q;
  logic [PRE_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (!hold) begin
      cnt_d = (cnt_q == TC) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clr && !hold && (cnt_q == TC);

endmodule

// File: rtl/self_clean_ctrl.sv
// Range-hood self-clean sequencer: start edge launches a fixed-length countdown shown as MM:SS BCD.
// Optional pause support is compiled in with the SELF_CLEAN_PAUSE_EN macro.
module self_clean_ctrl
  import hood_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int CLEAN_SECS = 180,
  parameter int SEC_W      = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_on,
  input  logic             start_clean,
  input  logic             abort,
`ifdef SELF_CLEAN_PAUSE_EN
  input  logic             pause,
`endif
  output logic             cleaning,
  output logic             paused,
  output logic [SEC_W-1:0] remaining,
  output logic [15:0]      mmss_bcd,
  output logic             done
);

  localparam logic [SEC_W-1:0] RELOAD_SECS = SEC_W'(CLEAN_SECS);
  localparam logic [15:0]      RELOAD_BCD  = sec_to_bcd(CLEAN_SECS);

  // Seconds digit borrows 00 -> 59 and decrements minutes, all in place.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    bcd_digit_t m10, m1, s10, s1;
    {m10, m1, s10, s1} = v;
    if (s1 != 4'd0) begin
      s1 = s1 - 4'd1;
    end else begin
      s1 = 4'd9;
      if (s10 != 4'd0) begin
        s10 = s10 - 4'd1;
      end else begin
        s10 = 4'd5;
        if (m1 != 4'd0) begin
          m1 = m1 - 4'd1;
        end else begin
          m1  = 4'd9;
          m10 = m10 - 4'd1;
        end
      end
    end
    return {m10, m1, s10, s1};
  endfunction

  logic pause_w;
`ifdef SELF_CLEAN_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  clean_state_e     state_q, state_d;
  logic [SEC_W-1:0] remaining_q, remaining_d;
  logic [15:0]      mmss_q, mmss_d;
  logic             done_q, done_d;
  logic             cleaning_q, paused_q;
  logic             start_low_q;
  logic             start_rise;
  logic             tick_w;
  logic             kill;

  // start_low_q resets to 0 so a level already high out of reset is not an edge.
  assign start_rise = start_clean && start_low_q;
  assign kill       = !is_on || abort;

  clean_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr ((state_q != ST_CLEANING) && (state_q != ST_PAUSED)),
    .hold(state_q != ST_CLEANING),
    .tick(tick_w)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    mmss_d      = mmss_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        remaining_d = RELOAD_SECS;
        mmss_d      = RELOAD_BCD;
        if (start_rise && !kill) begin
          state_d = ST_CLEANING;
        end
      end
      ST_CLEANING: begin
        if (kill) begin
          state_d     = ST_IDLE;
          remaining_d = RELOAD_SECS;
          mmss_d      = RELOAD_BCD;
        end else begin
          if (tick_w) begin
            if (remaining_q <= SEC_W'(1)) begin
              state_d     = ST_FINISHED;
              remaining_d = '0;
              mmss_d      = '0;
              done_d      = 1'b1;
            end else begin
              remaining_d = remaining_q - SEC_W'(1);
              mmss_d      = bcd_dec(mmss_q);
            end
          end
          if ((state_d == ST_CLEANING) && pause_w) begin
            state_d = ST_PAUSED;
          end
        end
      end
      ST_PAUSED: begin
        if (kill) begin
          state_d     = ST_IDLE;
          remaining_d = RELOAD_SECS;
          mmss_d      = RELOAD_BCD;
        end else if (!pause_w) begin
          state_d = ST_CLEANING;
        end
      end
      ST_FINISHED: begin
        if (!start_clean || !is_on) begin
          state_d     = ST_IDLE;
          remaining_d = RELOAD_SECS;
          mmss_d      = RELOAD_BCD;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        remaining_d = RELOAD_SECS;
        mmss_d      = RELOAD_BCD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= RELOAD_SECS;
      mmss_q      <= RELOAD_BCD;
      done_q      <= 1'b0;
      cleaning_q  <= 1'b0;
      paused_q    <= 1'b0;
      start_low_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      mmss_q      <= mmss_d;
      done_q      <= done_d;
      cleaning_q  <= (state_d == ST_CLEANING) || (state_d == ST_PAUSED);
      paused_q    <= (state_d == ST_PAUSED);
      start_low_q <= !start_clean;
    end
  end

  assign cleaning  = cleaning_q;
  assign remaining = remaining_q;
  assign mmss_bcd  = mmss_q;
  assign done      = done_q;
`ifdef SELF_CLEAN_PAUSE_EN
  assign paused = paused_q;
`else
  assign paused = 1'b0;
`endif

endmodule

// File: tb/tb_self_clean_ctrl.sv
// Directed bench for self_clean_ctrl at CLK_HZ=4: a 65 s instance driven from a vector
// table plus corner sequences, and a 1 s instance for the shortest cycle.
module tb_self_clean_ctrl;

  localparam int CLK_HZ = 4;
  localparam int SEC_W  = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic is_on = 1'b0, start_clean = 1'b0, abort = 1'b0;
  logic cleaning, paused, done;
  logic [SEC_W-1:0] remaining;
  logic [15:0] mmss_bcd;

  logic on1 = 1'b0, start1 = 1'b0;
  logic cleaning1, paused1, done1;
  logic [SEC_W-1:0] remaining1;
  logic [15:0] mmss1;
`ifdef SELF_CLEAN_PAUSE_EN
  logic pause = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  self_clean_ctrl #(.CLK_HZ(CLK_HZ), .CLEAN_SECS(65), .SEC_W(SEC_W)) u_dut (
    .clk(clk), .rst(rst), .is_on(is_on), .start_clean(start_clean), .abort(abort),
`ifdef SELF_CLEAN_PAUSE_EN
    .pause(pause),
`endif
    .cleaning(cleaning), .paused(paused), .remaining(remaining),
    .mmss_bcd(mmss_bcd), .done(done)
  );

  self_clean_ctrl #(.CLK_HZ(CLK_HZ), .CLEAN_SECS(1), .SEC_W(SEC_W)) u_dut1 (
    .clk(clk), .rst(rst), .is_on(on1), .start_clean(start1), .abort(1'b0),
`ifdef SELF_CLEAN_PAUSE_EN
    .pause(1'b0),
`endif
    .cleaning(cleaning1), .paused(paused1), .remaining(remaining1),
    .mmss_bcd(mmss1), .done(done1)
  );

  always @(negedge clk) if (done) done_cnt++;

  typedef struct packed {
    logic        start;
    logic        on;
    logic        abrt;
    int          cyc;
    logic        exp_clean;
    int          exp_rem;
    logic [15:0] exp_bcd;
    logic        exp_done;
  } vec_t;

  vec_t vecs [0:9];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    // start, on, abort, cycles, cleaning, remaining, mmss, done
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1,   1'b0, 65, 16'h0105, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1,   1'b1, 65, 16'h0105, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 4,   1'b1, 64, 16'h0104, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16,  1'b1, 60, 16'h0100, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 4,   1'b1, 59, 16'h0059, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 235, 1'b1, 1,  16'h0001, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1,   1'b0, 0,  16'h0000, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1,   1'b0, 0,  16'h0000, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 20,  1'b0, 0,  16'h0000, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 1,   1'b0, 65, 16'h0105, 1'b0};

    step(2);
    rst = 1'b0;
    step(1);
    check("reset cleaning", 32'(cleaning), 32'd0);
    check("reset remaining", 32'(remaining), 32'd65);
    check("reset mmss", 32'(mmss_bcd), 32'h0105);
    check("reset done", 32'(done), 32'd0);
    check("reset paused", 32'(paused), 32'd0);
    check("reset dut1 remaining", 32'(remaining1), 32'd1);

    // Full 65 s cycle with start held high
    for (int i = 0; i < 10; i++) begin
      start_clean = vecs[i].start;
      is_on       = vecs[i].on;
      abort       = vecs[i].abrt;
      step(vecs[i].cyc);
      check($sformatf("vec%0d cleaning", i), 32'(cleaning), 32'(vecs[i].exp_clean));
      check($sformatf("vec%0d remaining", i), 32'(remaining), 32'(vecs[i].exp_rem));
      check($sformatf("vec%0d mmss", i), 32'(mmss_bcd), 32'(vecs[i].exp_bcd));
      check($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].exp_done));
      $display("vec%0d: cleaning=%0d remaining=%0d mmss=%04h done=%0d", i, cleaning, remaining, mmss_bcd, done);
    end
    check("done pulses after full cycle", 32'(done_cnt), 32'd1);

    // Power drop at 00:30
    start_clean = 1'b1;
    step(1);
    check("pwr entry cleaning", 32'(cleaning), 32'd1);
    step(140);
    check("pwr at 00:30 remaining", 32'(remaining), 32'd30);
    check("pwr at 00:30 mmss", 32'(mmss_bcd), 32'h0030);
    is_on = 1'b0;
    step(1);
    check("pwr drop cleaning", 32'(cleaning), 32'd0);
    check("pwr drop remaining", 32'(remaining), 32'd65);
    check("pwr drop mmss", 32'(mmss_bcd), 32'h0105);
    step(3);
    check("pwr drop done pulses", 32'(done_cnt), 32'd1);
    $display("power-drop: cleaning=%0d remaining=%0d", cleaning, remaining);

    // Abort coinciding with the final tick
    is_on = 1'b1;
    start_clean = 1'b0;
    step(1);
    start_clean = 1'b1;
    step(1);
    check("abort entry cleaning", 32'(cleaning), 32'd1);
    step(259);
    check("abort at 00:01 mmss", 32'(mmss_bcd), 32'h0001);
    abort = 1'b1;
    step(1);
    check("abort+tick cleaning", 32'(cleaning), 32'd0);
    check("abort+tick remaining", 32'(remaining), 32'd65);
    check("abort+tick done", 32'(done), 32'd0);
    abort = 1'b0;
    step(2);
    check("held start no retrigger", 32'(cleaning), 32'd0);
    start_clean = 1'b0;
    step(1);
    start_clean = 1'b1;
    abort = 1'b1;
    step(1);
    check("abort blocks start edge", 32'(cleaning), 32'd0);
    abort = 1'b0;
    step(1);
    check("no start after blocked edge", 32'(cleaning), 32'd0);
    check("abort done pulses", 32'(done_cnt), 32'd1);
    $display("abort: cleaning=%0d remaining=%0d done_cnt=%0d", cleaning, remaining, done_cnt);

`ifdef SELF_CLEAN_PAUSE_EN
    // Pause for 10 clocks at 00:50
    start_clean = 1'b0;
    step(1);
    start_clean = 1'b1;
    step(1);
    step(62);
    check("pause pre remaining", 32'(remaining), 32'd50);
    pause = 1'b1;
    step(1);
    check("pause paused", 32'(paused), 32'd1);
    check("pause cleaning", 32'(cleaning), 32'd1);
    step(9);
    check("pause frozen remaining", 32'(remaining), 32'd50);
    check("pause frozen mmss", 32'(mmss_bcd), 32'h0050);
    pause = 1'b0;
    step(1);
    check("resume paused", 32'(paused), 32'd0);
    check("resume remaining", 32'(remaining), 32'd50);
    step(1);
    check("resume tick remaining", 32'(remaining), 32'd49);
    check("resume tick mmss", 32'(mmss_bcd), 32'h0049);
    $display("pause: remaining=%0d mmss=%04h", remaining, mmss_bcd);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
`endif

    // One-second cycle on the second instance
    on1 = 1'b1;
    step(1);
    start1 = 1'b1;
    step(1);
    check("s1 entry cleaning", 32'(cleaning1), 32'd1);
    check("s1 entry mmss", 32'(mmss1), 32'h0001);
    step(3);
    check("s1 pre-done done", 32'(done1), 32'd0);
    check("s1 pre-done remaining", 32'(remaining1), 32'd1);
    step(1);
    check("s1 done", 32'(done1), 32'd1);
    check("s1 done remaining", 32'(remaining1), 32'd0);
    check("s1 done cleaning", 32'(cleaning1), 32'd0);
    step(1);
    check("s1 done single", 32'(done1), 32'd0);
    check("s1 finished hold", 32'(mmss1), 32'h0000);
    start1 = 1'b0;
    step(1);
    check("s1 back to idle remaining", 32'(remaining1), 32'd1);
    check("s1 back to idle mmss", 32'(mmss1), 32'h0001);
    $display("one-second: remaining=%0d mmss=%04h", remaining1, mmss1);

    // Asynchronous reset mid-cycle
    start_clean = 1'b0;
    step(1);
    start_clean = 1'b1;
    step(10);
    check("pre-reset remaining", 32'(remaining), 32'd63);
    check("pre-reset mmss", 32'(mmss_bcd), 32'h0103);
    #2 rst = 1'b1;
    #1;
    check("async reset cleaning", 32'(cleaning), 32'd0);
    check("async reset remaining", 32'(remaining), 32'd65);
    check("async reset mmss", 32'(mmss_bcd), 32'h0105);
    check("async reset done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(3);
    check("start level after reset", 32'(cleaning), 32'd0);
    start_clean = 1'b0;
    step(1);
    start_clean = 1'b1;
    step(1);
    check("start edge after reset", 32'(cleaning), 32'd1);
    $display("reset: cleaning=%0d remaining=%0d", cleaning, remaining);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
